chacha_core: RTL

//   Parametrised ChaCha block-function engine: next generation of the byte-loaded ChaCha block.

---
 rtl/chacha_core.sv | 130 +++++++++++++
 1 files changed

// File: rtl/chacha_core.sv
// ChaCha block-function engine: byte-loaded input state, one half quarter-round per cycle,
// feed-forward add into an output register and optional block-counter auto-increment.
module chacha_core #(
   parameter int ROUNDS        = 20,
   parameter int COUNTER_WIDTH = 32,
   parameter int AUTO_INC      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       write,
   input  logic [5:0] addr_in,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       start,
   output logic       ready,
   output logic       done,
   output logic       out_valid
);
   localparam int         STEPS     = 8 * ROUNDS;
   localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

   // Handshake: write and start are taken only on an edge where ready=1; a write wins over a
   // simultaneous start, and done is a one-cycle pulse coinciding with the return of ready.
   typedef enum logic [1:0] {IDLE, COPY, ROUND, FINAL} state_t;

   state_t      state_q, state_d;
   logic [7:0]  step_q;
   logic        done_q, valid_q;
   logic [31:0] in_st  [16];
   logic [31:0] wk_st  [16];
   logic [31:0] out_st [16];

   logic [1:0]  qi;
   logic        hi_half;
   logic [3:0]  ia, ib, ic, id;
   logic [31:0] a0, b0, c0, d0, a1, b1, c1, d1, dx, bx;

   // Operand selection: step[3] picks column vs diagonal round, step[2:1] the quarter-round.
   always_comb begin
      qi      = step_q[2:1];
      hi_half = step_q[0];
      ia      = {2'b00, qi};
      if (step_q[3]) begin
         ib = {2'b01, qi + 2'd1};
         ic = {2'b10, qi + 2'd2};
         id = {2'b11, qi + 2'd3};
      end else begin
         ib = {2'b01, qi};
         ic = {2'b10, qi};
         id = {2'b11, qi};
      end
      a0 = wk_st[ia];
      b0 = wk_st[ib];
      c0 = wk_st[ic];
      d0 = wk_st[id];
      a1 = a0 + b0;
      dx = d0 ^ a1;
      d1 = hi_half ? {dx[23:0], dx[31:24]} : {dx[15:0], dx[31:16]};
      c1 = c0 + d1;
      bx = b0 ^ c1;
      b1 = hi_half ? {bx[24:0], bx[31:25]} : {bx[19:0], bx[31:20]};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !write) state_d = COPY;
         COPY:    state_d = ROUND;
         ROUND:   if (step_q == LAST_STEP) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            in_st[i]  <= '0;
            wk_st[i]  <= '0;
            out_st[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (write) begin
                  in_st[addr_in[5:2]][{addr_in[1:0], 3'b000} +: 8] <= data_in;
                  valid_q <= 1'b0;
               end
            end
            COPY: begin
               for (int i = 0; i < 16; i++) wk_st[i] <= in_st[i];
               step_q <= '0;
            end
            ROUND: begin
               wk_st[ia] <= a1;
               wk_st[ib] <= b1;
               wk_st[ic] <= c1;
               wk_st[id] <= d1;
               step_q    <= step_q + 8'd1;
            end
            FINAL: begin
               for (int i = 0; i < 16; i++) out_st[i] <= wk_st[i] + in_st[i];
               step_q  <= '0;
               done_q  <= 1'b1;
               valid_q <= 1'b1;
               // Counter bump uses the pre-edge input, so this block's output is unaffected.
               if (AUTO_INC != 0) begin
                  if (COUNTER_WIDTH == 64)
                     {in_st[13], in_st[12]} <= {in_st[13], in_st[12]} + 64'd1;
                  else
                     in_st[12] <= in_st[12] + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready     = (state_q == IDLE);
   assign done      = done_q;
   assign out_valid = valid_q;
   assign data_out  = out_st[addr_in[5:2]][{addr_in[1:0], 3'b000} +: 8];

endmodule
